// File: rtl/mig_tm_pkg.sv
// +----------------------------------------------------------------------------+
// | mig_tm_pkg : shared constants, FSM encoding and record-address helper for  |
// |              the per-DSID traffic monitor.                                 |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

package mig_tm_pkg;

  localparam logic [1:0] TM_RD_REQ   = 2'd0;
  localparam logic [1:0] TM_RD_BYTES = 2'd1;
  localparam logic [1:0] TM_WR_REQ   = 2'd2;
  localparam logic [1:0] TM_WR_BYTES = 2'd3;

  localparam int TM_ADDR_SLOT_LSB = 8;
  localparam int TM_ADDR_SLOT_W   = 8;
  localparam int TM_ADDR_ID_LSB   = 2;
  localparam int TM_ADDR_ID_W     = 2;

  typedef enum logic {
    TM_ST_IDLE = 1'b0,
    TM_ST_DUMP = 1'b1
  } tm_state_e;

  function automatic logic [31:0] tm_rec_addr(input logic [7:0] slot, input logic [1:0] id);
    logic [31:0] a;
    a = 32'h0;
    a[TM_ADDR_SLOT_LSB +: TM_ADDR_SLOT_W] = slot;
    a[TM_ADDR_ID_LSB +: TM_ADDR_ID_W]     = id;
    return a;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mig_tm_sat_counter.sv
// +----------------------------------------------------------------------------+
// | mig_tm_sat_counter : saturating accumulator with snapshot-and-clear shadow. |
// | Revision           : 1.0                                                   |
// +----------------------------------------------------------------------------+
`default_nettype none

module mig_tm_sat_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc_en,
  input  logic [15:0]          inc,
  input  logic                 snap,
  output logic [CNT_WIDTH-1:0] live,
  output logic [CNT_WIDTH-1:0] shadow
);

  localparam int SUM_W = ((CNT_WIDTH > 16) ? CNT_WIDTH : 16) + 1;

  logic [SUM_W-1:0]     base;
  logic [SUM_W-1:0]     sum;
  logic [SUM_W-1:0]     max_val;
  logic [CNT_WIDTH-1:0] next_live;

  // On a snapshot the increment lands on a cleared counter, not the old value.
  assign base      = snap ? '0 : SUM_W'(live);
  assign sum       = base + SUM_W'(inc);
  assign max_val   = SUM_W'({CNT_WIDTH{1'b1}});
  assign next_live = (sum > max_val) ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live   <= '0;
      shadow <= '0;
    end else begin
      if (snap) shadow <= live;
      if (inc_en)    live <= next_live;
      else if (snap) live <= '0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mig_traffic_monitor.sv
// +----------------------------------------------------------------------------+
// | mig_traffic_monitor : snoops AR/AW handshakes, counts per-DSID traffic per  |
// |                       window and streams snapshots as APM records.         |
// | Revision            : 1.0                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module mig_traffic_monitor
  import mig_tm_pkg::*;
#(
  parameter int C_DSID_WIDTH    = 16,
  parameter int C_NUM_SLOTS     = 4,
  parameter int C_WINDOW_CYCLES = 1000000,
  parameter int C_CNT_WIDTH     = 32
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    s_axi_arvalid,
  input  logic                    s_axi_arready,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [C_DSID_WIDTH-1:0] s_axi_aruser,
  input  logic                    s_axi_awvalid,
  input  logic                    s_axi_awready,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [C_DSID_WIDTH-1:0] s_axi_awuser,
  input  logic                    enable,
  output logic                    APM_VALID,
  output logic [31:0]             APM_ADDR,
  output logic [31:0]             APM_DATA
);

  localparam int SLOT_W  = $clog2(C_NUM_SLOTS);
  localparam int NUM_CNT = 4 * C_NUM_SLOTS;
  localparam int REC_W   = SLOT_W + 2;
  localparam int WIN_W   = $clog2(C_WINDOW_CYCLES);
  localparam logic [REC_W-1:0] LAST_REC = REC_W'(NUM_CNT - 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(C_WINDOW_CYCLES - 1);

  if (C_WINDOW_CYCLES < 4 * C_NUM_SLOTS + 2) begin : g_chk_window
    $error("C_WINDOW_CYCLES too short to finish a dump");
  end
  if ((C_NUM_SLOTS < 2) || (C_NUM_SLOTS > 64) || ((C_NUM_SLOTS & (C_NUM_SLOTS - 1)) != 0)) begin : g_chk_slots
    $error("C_NUM_SLOTS must be a power of two in 2..64");
  end
  if ((C_CNT_WIDTH < 1) || (C_CNT_WIDTH > 32)) begin : g_chk_cnt
    $error("C_CNT_WIDTH must be 1..32");
  end

  logic              ar_evt, aw_evt;
  logic [SLOT_W-1:0] ar_slot, aw_slot;
  logic [15:0]       ar_bytes, aw_bytes;

  assign ar_evt   = s_axi_arvalid && s_axi_arready && enable &&
                    (s_axi_aruser < C_DSID_WIDTH'(C_NUM_SLOTS));
  assign aw_evt   = s_axi_awvalid && s_axi_awready && enable &&
                    (s_axi_awuser < C_DSID_WIDTH'(C_NUM_SLOTS));
  assign ar_slot  = s_axi_aruser[SLOT_W-1:0];
  assign aw_slot  = s_axi_awuser[SLOT_W-1:0];
  assign ar_bytes = (16'(s_axi_arlen) + 16'd1) << s_axi_arsize;
  assign aw_bytes = (16'(s_axi_awlen) + 16'd1) << s_axi_awsize;

  logic [WIN_W-1:0] win_cnt;
  logic             win_end;

  assign win_end = (win_cnt == WIN_LAST);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)     win_cnt <= '0;
    else if (win_end) win_cnt <= '0;
    else              win_cnt <= win_cnt + WIN_W'(1);
  end

  // Counter index i = slot*4 + id, which is also the dump record order.
  logic [C_CNT_WIDTH-1:0] live_cnt   [NUM_CNT];
  logic [C_CNT_WIDTH-1:0] shadow_cnt [NUM_CNT];

  for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
    localparam int         SLOT     = i / 4;
    localparam logic [1:0] ID       = 2'(i % 4);
    localparam bit         IS_RD    = (ID == TM_RD_REQ) || (ID == TM_RD_BYTES);
    localparam bit         IS_BYTES = (ID == TM_RD_BYTES) || (ID == TM_WR_BYTES);

    logic        hit;
    logic [15:0] inc;

    assign hit = IS_RD ? (ar_evt && (ar_slot == SLOT_W'(SLOT)))
                       : (aw_evt && (aw_slot == SLOT_W'(SLOT)));
    assign inc = IS_BYTES ? (IS_RD ? ar_bytes : aw_bytes) : 16'd1;

    mig_tm_sat_counter #(
      .CNT_WIDTH (C_CNT_WIDTH)
    ) u_cnt (
      .clk    (aclk),
      .rst_n  (aresetn),
      .inc_en (hit),
      .inc    (inc),
      .snap   (win_end),
      .live   (live_cnt[i]),
      .shadow (shadow_cnt[i])
    );
  end

  tm_state_e        state_q, state_d;
  logic [REC_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      data_q, data_d;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= TM_ST_IDLE;
      idx_q   <= '0;
      valid_q <= 1'b0;
      addr_q  <= 32'h0;
      data_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // Record 0 is taken from the live counter in the wrap cycle itself (same
  // value the shadow captures), so the stream starts the cycle after window end.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      TM_ST_IDLE: begin
        if (win_end) begin
          state_d = TM_ST_DUMP;
          idx_d   = REC_W'(1);
          valid_d = 1'b1;
          addr_d  = tm_rec_addr(8'h00, TM_RD_REQ);
          data_d  = 32'(live_cnt[0]);
        end
      end
      TM_ST_DUMP: begin
        valid_d = 1'b1;
        addr_d  = tm_rec_addr(8'(idx_q[REC_W-1:2]), idx_q[1:0]);
        data_d  = 32'(shadow_cnt[idx_q]);
        idx_d   = idx_q + REC_W'(1);
        if (idx_q == LAST_REC) state_d = TM_ST_IDLE;
      end
      default: state_d = TM_ST_IDLE;
    endcase
  end

  assign APM_VALID = valid_q;
  assign APM_ADDR  = addr_q;
  assign APM_DATA  = data_q;

endmodule

`default_nettype wire
